// File: rtl/jtag_axi_master_ctrl.sv
// JTAG debug command sequencer: one AXI4-Lite read or write per command,
// with a per-transaction hung-slave timeout and a status return path.
module jtag_axi_master_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_wr,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_strb,
  output logic                sts_valid,
  output logic [DATA_W-1:0]   sts_rdata,
  output logic [1:0]          sts_resp,
  output logic                sts_timeout,
  output logic                busy,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_wvalid,
  input  logic                m_wready,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_bvalid,
  output logic                m_bready,
  input  logic [1:0]          m_bresp,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [ADDR_W-1:0]   m_araddr,
  input  logic                m_rvalid,
  output logic                m_rready,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              awvalid_d, wvalid_d, bready_d, arvalid_d, rready_d;
  logic [1:0]        resp_d;
  logic [DATA_W-1:0] rdata_d;
  logic              to_d, accept, abort, expire;

  assign cmd_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign sts_valid = (state == DONE);
  assign expire    = (TIMEOUT_CYC != 0) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      m_awvalid   <= 1'b0;
      m_wvalid    <= 1'b0;
      m_bready    <= 1'b0;
      m_arvalid   <= 1'b0;
      m_rready    <= 1'b0;
      m_awaddr    <= '0;
      m_araddr    <= '0;
      m_wdata     <= '0;
      m_wstrb     <= '0;
      sts_rdata   <= '0;
      sts_resp    <= 2'b00;
      sts_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      m_awvalid   <= awvalid_d;
      m_wvalid    <= wvalid_d;
      m_bready    <= bready_d;
      m_arvalid   <= arvalid_d;
      m_rready    <= rready_d;
      sts_rdata   <= rdata_d;
      sts_resp    <= resp_d;
      sts_timeout <= to_d;
      if (accept) begin
        m_awaddr <= cmd_addr;
        m_araddr <= cmd_addr;
        m_wdata  <= cmd_wdata;
        m_wstrb  <= cmd_strb;
      end
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    awvalid_d = m_awvalid;
    wvalid_d  = m_wvalid;
    bready_d  = m_bready;
    arvalid_d = m_arvalid;
    rready_d  = m_rready;
    resp_d    = sts_resp;
    rdata_d   = sts_rdata;
    to_d      = sts_timeout;
    accept    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: if (cmd_valid) begin
        accept = 1'b1;
        cnt_d  = '0;
        to_d   = 1'b0;
        if (cmd_wr) begin
          state_d   = WR_REQ;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
        end else begin
          state_d   = RD_REQ;
          arvalid_d = 1'b1;
        end
      end
      WR_REQ: begin
        cnt_d = cnt + 1'b1;
        if (m_awready) awvalid_d = 1'b0;
        if (m_wready)  wvalid_d  = 1'b0;
        // AW and W retire independently; a channel already done counts as complete
        if ((!m_awvalid || m_awready) && (!m_wvalid || m_wready)) begin
          state_d  = WR_RESP;
          bready_d = 1'b1;
        end else if (expire) abort = 1'b1;
      end
      WR_RESP: begin
        cnt_d = cnt + 1'b1;
        if (m_bvalid) begin
          resp_d   = m_bresp;
          bready_d = 1'b0;
          state_d  = DONE;
        end else if (expire) abort = 1'b1;
      end
      RD_REQ: begin
        cnt_d = cnt + 1'b1;
        if (m_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = RD_DATA;
        end else if (expire) abort = 1'b1;
      end
      RD_DATA: begin
        cnt_d = cnt + 1'b1;
        if (m_rvalid) begin
          rdata_d  = m_rdata;
          resp_d   = m_rresp;
          rready_d = 1'b0;
          state_d  = DONE;
        end else if (expire) abort = 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A completing handshake takes priority; abort only fires when none occurred
    if (abort) begin
      awvalid_d = 1'b0;
      wvalid_d  = 1'b0;
      bready_d  = 1'b0;
      arvalid_d = 1'b0;
      rready_d  = 1'b0;
      to_d      = 1'b1;
      resp_d    = 2'b10;
      state_d   = DONE;
    end
  end

endmodule

// File: tb/tb_jtag_axi_master_ctrl.sv
// Directed bench: a vector table of transactions against a bench-side AXI slave,
// plus hand sequences for reset behaviour.
module tb_jtag_axi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_wr;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_strb;
  logic        sts_valid, sts_timeout, busy;
  logic [31:0] sts_rdata;
  logic [1:0]  sts_resp;
  logic        m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
  logic        m_arvalid, m_arready, m_rvalid, m_rready;
  logic [31:0] m_awaddr, m_wdata, m_araddr, m_rdata;
  logic [3:0]  m_wstrb;
  logic [1:0]  m_bresp, m_rresp;

  int ncmp = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  jtag_axi_master_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(8)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .sts_valid(sts_valid), .sts_rdata(sts_rdata), .sts_resp(sts_resp),
    .sts_timeout(sts_timeout), .busy(busy),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp)
  );

  logic [142:0] outs, rst_exp;
  assign outs = {cmd_ready, sts_valid, busy, m_awvalid, m_wvalid, m_bready, m_arvalid,
                 m_rready, sts_timeout, sts_resp, sts_rdata, m_awaddr, m_wdata, m_wstrb, m_araddr};

  // a_at/w_at/r_at: cycle (1 = first cycle after acceptance) from which the slave
  // asserts addr-ready / wready / response-valid; 99 = never
  typedef struct {
    logic        wr;
    logic [31:0] addr, wdata;
    logic [3:0]  strb;
    int          a_at, w_at, r_at;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          exp_av, exp_wv, exp_ahs, exp_sts;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  vec_t vecs[9];
  vec_t rv;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
  endtask

  // Entered and left at #1 after a rising edge.
  task automatic run_txn(input vec_t v, input int id);
    int av = 0, wv = 0, ahs = 0, nsts = 0, sts_cyc = 0, bad = 0;
    logic a_done = 0, w_done = 0, r_done = 0;
    logic [1:0] g_resp = 0;
    logic [31:0] g_rdata = 0;
    logic g_to = 0;
    string tag;
    tag = $sformatf("v%0d", id);
    cmd_valid = 1; cmd_wr = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata; cmd_strb = v.strb;
    chk({tag, "_cmd_ready"}, cmd_ready, 1);
    @(posedge clk); #1;
    cmd_valid = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 1) begin
        if (v.wr) chk({tag, "_aw_w_first"}, {m_awvalid, m_wvalid, m_awaddr, m_wdata, m_wstrb},
                      {2'b11, v.addr, v.wdata, v.strb});
        else      chk({tag, "_ar_first"}, {m_arvalid, m_araddr}, {1'b1, v.addr});
      end
      if (sts_valid) nsts++;
      if (sts_cyc != 0) break;
      if (sts_valid) begin
        sts_cyc = k; g_resp = sts_resp; g_rdata = sts_rdata; g_to = sts_timeout;
      end
      if (!busy || cmd_ready) bad++;
      if (v.wr) begin
        if (m_arvalid || m_rready || (m_bready && !(a_done && w_done))) bad++;
        if (m_awvalid) av++;
        if (m_wvalid) wv++;
      end else begin
        if (m_awvalid || m_wvalid || m_bready || (m_rready && !a_done)) bad++;
        if (m_arvalid) av++;
      end
      // slave drives this cycle's inputs
      m_awready = v.wr && (k >= v.a_at);
      m_wready  = v.wr && (k >= v.w_at);
      m_bvalid  = v.wr && (k >= v.r_at) && !r_done;
      m_bresp   = v.resp;
      m_arready = !v.wr && (k >= v.a_at);
      m_rvalid  = !v.wr && (k >= v.r_at) && !r_done;
      m_rdata   = v.rdata;
      m_rresp   = v.resp;
      if (v.wr) begin
        if (m_awvalid && m_awready) begin ahs++; a_done = 1; end
        if (m_wvalid && m_wready) w_done = 1;
        if (m_bvalid && m_bready) r_done = 1;
      end else begin
        if (m_arvalid && m_arready) begin ahs++; a_done = 1; end
        if (m_rvalid && m_rready) r_done = 1;
      end
      @(posedge clk); #1;
    end
    idle_inputs();
    chk({tag, "_addr_valid_cycles"}, av, v.exp_av);
    if (v.wr) chk({tag, "_wvalid_cycles"}, wv, v.exp_wv);
    chk({tag, "_addr_handshakes"}, ahs, v.exp_ahs);
    chk({tag, "_sts_pulses"}, nsts, 1);
    chk({tag, "_sts_cycle"}, sts_cyc, v.exp_sts);
    chk({tag, "_sts_resp"}, g_resp, v.exp_resp);
    chk({tag, "_sts_rdata"}, g_rdata, v.exp_rdata);
    chk({tag, "_sts_timeout"}, g_to, v.exp_to);
    chk({tag, "_protocol"}, bad, 0);
    chk({tag, "_idle_after"}, {cmd_ready, busy}, 2'b10);
  endtask

  initial begin
    //            wr  addr          wdata         strb  a   w   r   resp   rdata         av wv ahs sts eresp  erdata        eto
    vecs[0] = '{1'b1, 32'h1000_0004, 32'hDEAD_BEEF, 4'hF, 1,  1,  3,  2'b00, 32'h0,         1, 1, 1, 4, 2'b00, 32'h0,         1'b0};
    vecs[1] = '{1'b1, 32'h0000_0ABC, 32'h1234_5678, 4'h0, 4,  1,  5,  2'b01, 32'h0,         4, 1, 1, 6, 2'b01, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h2000_0000, 32'h0,         4'h0, 1,  0,  2,  2'b11, 32'hCAFE_F00D, 1, 0, 1, 3, 2'b11, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 32'h3000_0008, 32'h0BAD_F00D, 4'h5, 1,  1,  2,  2'b00, 32'h0,         1, 1, 1, 3, 2'b00, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 32'h2000_0010, 32'h0,         4'h0, 99, 0,  99, 2'b00, 32'hBAD0_BAD0, 8, 0, 0, 9, 2'b10, 32'hCAFE_F00D, 1'b1};
    vecs[5] = '{1'b0, 32'h2000_0014, 32'h0,         4'h0, 3,  0,  8,  2'b00, 32'h55AA_55AA, 3, 0, 1, 9, 2'b00, 32'h55AA_55AA, 1'b0};
    vecs[6] = '{1'b1, 32'h3000_0000, 32'h1111_1111, 4'hF, 1,  1,  99, 2'b00, 32'h0,         1, 1, 1, 9, 2'b10, 32'h55AA_55AA, 1'b1};
    vecs[7] = '{1'b0, 32'h4000_0001, 32'h0,         4'h0, 1,  0,  2,  2'b00, 32'h0102_0304, 1, 0, 1, 3, 2'b00, 32'h0102_0304, 1'b0};
    vecs[8] = '{1'b1, 32'h5000_0000, 32'h2222_2222, 4'h3, 99, 2,  99, 2'b00, 32'h0,         8, 2, 0, 9, 2'b10, 32'h0102_0304, 1'b1};
    rv      = '{1'b0, 32'h6000_0000, 32'h0,         4'h0, 1,  0,  2,  2'b00, 32'h0A0B_0C0D, 1, 0, 1, 3, 2'b00, 32'h0A0B_0C0D, 1'b0};
    rst_exp = {1'b1, 142'd0};

    rst = 1; cmd_wr = 0; cmd_addr = 0; cmd_wdata = 0; cmd_strb = 0;
    m_bresp = 0; m_rdata = 0; m_rresp = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", outs, rst_exp);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_txn(vecs[i], i);

    // reset while waiting for B: everything drops, no status pulse
    cmd_valid = 1; cmd_wr = 1; cmd_addr = 32'h7000_0000; cmd_wdata = 32'h3333_3333; cmd_strb = 4'hF;
    @(posedge clk); #1;
    cmd_valid = 0; m_awready = 1; m_wready = 1;
    @(posedge clk); #1;
    m_awready = 0; m_wready = 0;
    chk("rst_pre_bready", {m_bready, busy}, 2'b11);
    rst = 1;
    @(posedge clk); #1;
    chk("rst_mid_outs", outs, rst_exp);
    rst = 0;
    @(posedge clk); #1;
    chk("rst_no_sts", {sts_valid, busy, cmd_ready}, 3'b001);
    run_txn(rv, 9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
